log_arbiter: RTL

//  Shares one pipelined Q5.10 ln(x) unit among N_REQ requesters (HSS feature stages).

---
 rtl/log_arbiter_if.sv | 33 +++
 rtl/log_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/log_arbiter_if.sv
// Bundle of the request, ln-unit and response signals that connect the
// requesters and the shared ln(x) unit to log_arbiter.
interface log_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();

    logic                  en;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*DW-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;
    logic [DW-1:0]         log_data;
    logic [DW-1:0]         log_result;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err;
    logic                  busy;

    // Environment side: requesters, enable and the ln unit output.
    modport master (
        output en, req_valid, req_data, log_result,
        input  req_ready, log_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    // Arbiter side.
    modport slave (
        input  en, req_valid, req_data, log_result,
        output req_ready, log_data, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/log_arbiter.sv
// Round-robin arbiter sharing one pipelined Q5.10 ln(x) unit among N_REQ
// requesters. A tag pipe follows every issued operand so its result is
// returned to the originating requester, flagged when ln is undefined.
// The response registers form the last stage of the tag pipe, so a grant
// in cycle t produces rsp_valid in cycle t+LAT+1. LAT must be at least 1.
module log_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int LAT   = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic          CLK,
    input logic          RST,
    log_arbiter_if.slave bus
);

    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
        logic           err;
    } tag_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    tag_t            tag [LAT];

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             found;
    logic [CW-1:0]    cand;
    logic [DW-1:0]    operand;
    logic             operand_err;
    logic             pending;

    logic [DW-1:0]    log_data_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [DW-1:0]    rsp_data_q;
    logic             rsp_err_q;

    // State register of the enable/drain controller.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: drain leaves to IDLE once only the response stage can still
    // hold a tag, so busy drops the cycle after the last response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.en) begin
                    state_next = RUN;
                end else if (!pending) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Round-robin search from the pointer, wrapping past N_REQ-1 back to 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (state == RUN && bus.en) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, ptr} + CW'(k);
                if (cand >= CW'(N_REQ)) begin
                    cand = cand - CW'(N_REQ);
                end
                if (!found && bus.req_valid[cand[IDW-1:0]]) begin
                    found     = 1'b1;
                    grant_idx = cand[IDW-1:0];
                end
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Select the granted operand and flag values where ln is undefined.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                operand = bus.req_data[i*DW +: DW];
            end
        end
        operand_err = operand[DW-1] | (operand == '0);
    end

    // Tags still inside the pipe ahead of the response stage.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            pending = pending | tag[k].v;
        end
    end

    // Pointer, ln operand register, tag pipe and response stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr         <= '0;
            log_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                tag[k] <= '0;
            end
        end else begin
            if (found) begin
                if (grant_idx == IDW'(N_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + 1'b1;
                end
                if (!operand_err) begin
                    log_data_q <= operand;
                end
            end
            tag[0] <= '{v: found, id: grant_idx, err: operand_err & found};
            for (int k = 1; k < LAT; k++) begin
                tag[k] <= tag[k-1];
            end
            rsp_valid_q <= tag[LAT-1].v;
            if (tag[LAT-1].v) begin
                rsp_id_q   <= tag[LAT-1].id;
                rsp_err_q  <= tag[LAT-1].err;
                rsp_data_q <= tag[LAT-1].err ? {1'b1, {(DW-1){1'b0}}} : bus.log_result;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.log_data  = log_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE) | pending | rsp_valid_q;

endmodule
